// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB-first, carry held in a flop.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port for two's-complement a - b.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             cy_r;
  logic [CW-1:0]    cnt_r;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic [WIDTH-1:0] res_next_s;
  logic [WIDTH-1:0] b_load_s;
  logic             cy_load_s;

  full_adder u_fa (
    .a  (a_sr_r[0]),
    .b  (b_sr_r[0]),
    .ci (cy_r),
    .s  (fa_sum_s),
    .co (fa_carry_s)
  );

  // Next result shift value: new sum bit enters at the MSB end.
  always_comb begin
    res_next_s            = res_sr_r >> 1;
    res_next_s[WIDTH-1]   = fa_sum_s;
  end

  // Operand/carry values captured on an accepted start.
  always_comb begin
    b_load_s  = b;
    cy_load_s = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load_s  = ~b;
      cy_load_s = 1'b1;
    end else begin
      b_load_s  = b;
      cy_load_s = cin;
    end
`endif
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_sr_r    <= {WIDTH{1'b0}};
      b_sr_r    <= {WIDTH{1'b0}};
      res_sr_r  <= {WIDTH{1'b0}};
      cy_r      <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      carry_out <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr_r  <= a;
            b_sr_r  <= b_load_s;
            cy_r    <= cy_load_s;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_sr_r   <= a_sr_r >> 1;
          b_sr_r   <= b_sr_r >> 1;
          res_sr_r <= res_next_s;
          cy_r     <= fa_carry_s;
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          // Result register loads only on the last bit so partial sums never show.
          if (cnt_r == LAST) begin
            sum       <= res_next_s;
            carry_out <= fa_carry_s;
            done      <= 1'b1;
            state_r   <= DONE;
          end else begin
            done      <= 1'b0;
            state_r   <= RUN;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder: WIDTH=16 instance plus a WIDTH=1 instance.
module tb_serial_adder;

  localparam int W = 16;

  typedef struct {
    logic [W:0] val;
    int         cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  logic         start1;
  logic         sub1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         cin1;
  logic         busy1;
  logic         done1;
  logic [0:0]   sum1;
  logic         carry_out1;

  int   checks;
  int   failures;
  int   cyc;
  exp_t exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub1),
`endif
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .carry_out (carry_out1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every done pulse.
  initial begin : monitor
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", {15'd0, carry_out, sum}, {15'd0, e.val});
          check("latency", cyc - e.cyc, W + 1);
        end
      end
      prev_done = done;
    end
  end

  // Wait (bounded) for done, counting cycles with busy high.
  task automatic wait_done(output int busy_cnt);
    bit seen;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                         input logic s, input logic [W:0] expv);
    int bc;
    exp_t e;
    @(negedge clk);
    a = av; b = bv; cin = c; sub = s; start = 1'b1;
    e.val = expv; e.cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~c;
    if (busy) bc = 1; else bc = 0;
    begin
      int more;
      wait_done(more);
      bc += more;
    end
    check("busy_cycles", bc, W + 1);
    @(negedge clk);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin : stim
    exp_t e;
    int bc;
    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
    start1 = 1'b0; sub1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {15'd0, carry_out, sum}, 32'd0);
    rst_n = 1'b1;

    run_add(16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555);
    run_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000);
    run_add(16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000);
    run_add(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF);
    run_add(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 17'h0FFFF);

    // Start held high through RUN: second request must wait for IDLE.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
    e.val = 17'h0100E; e.cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555;
    wait_done(bc);
    e.val = 17'h0FFFF; e.cyc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    check("hold_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("hold_second_accept", {31'd0, busy}, 32'd1);
    wait_done(bc);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", {15'd0, carry_out, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_add(16'h0003, 16'h0004, 1'b0, 1'b0, 17'h00007);

`ifdef SERIAL_ADDER_SUB_EN
    run_add(16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE);
    run_add(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002);
`endif

    // WIDTH=1 instance: 1+1+1 and 0+1+0.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    check("w1_done_early", {31'd0, done1}, 32'd0);
    @(negedge clk);
    check("w1_done", {31'd0, done1}, 32'd1);
    check("w1_result", {30'd0, carry_out1, sum1}, 32'd3);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("w1_done_b", {31'd0, done1}, 32'd1);
    check("w1_result_b", {30'd0, carry_out1, sum1}, 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
